// File: rtl/tick_sched_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module  : tick_sched_ctrl                                               |
// | Purpose : shared prescaler feeding NCH programmable tick/clock dividers |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tick_sched_ctrl #(
  parameter int NCH      = 4,
  parameter int CW       = 20,
  parameter int PRESCALE = 50
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(NCH):0]     wr_addr,
  input  logic [CW-1:0]            wr_data,
  output logic [NCH-1:0]           tick,
  output logic [NCH-1:0]           clk_out,
  output logic [NCH-1:0]           busy
);

  localparam int c_CHW = $clog2(NCH);
  localparam int c_PW  = $clog2(PRESCALE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [c_PW-1:0] r_pcnt;
  logic            w_base;

  assign w_base = (r_pcnt == c_PW'(PRESCALE - 1));

  always_ff @(posedge clk_in) begin
    if (rst || w_base) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + c_PW'(1);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_shadow;
    logic [CW-1:0] r_adiv;
    logic          r_oneshot;
    logic          r_tick;
    logic          r_clk;
    logic          r_busy;

    logic          w_sel;
    logic          w_div_wr;
    logic          w_ctrl_wr;
    logic [CW-1:0] w_div_next;
    logic          w_oneshot_next;
    logic          w_wrap;

    assign w_sel          = wr_en && (wr_addr[c_CHW:1] == c_CHW'(i));
    assign w_div_wr       = w_sel && !wr_addr[0];
    assign w_ctrl_wr      = w_sel &&  wr_addr[0];
    // A DIV write landing on the same edge as a reload takes effect immediately.
    assign w_div_next     = w_div_wr  ? wr_data    : r_shadow;
    assign w_oneshot_next = w_ctrl_wr ? wr_data[1] : r_oneshot;
    assign w_wrap         = (r_cnt == (r_adiv - CW'(1)));

    always_ff @(posedge clk_in) begin
      if (rst) begin
        r_state   <= ST_IDLE;
        r_cnt     <= '0;
        r_shadow  <= '0;
        r_adiv    <= '0;
        r_oneshot <= 1'b0;
        r_tick    <= 1'b0;
        r_clk     <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        r_tick <= 1'b0;
        if (w_div_wr) begin
          r_shadow <= wr_data;
        end
        if (w_ctrl_wr) begin
          r_oneshot <= wr_data[1];
        end

        if (w_ctrl_wr && !wr_data[0]) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_clk   <= 1'b0;
        end else if (w_ctrl_wr && (r_state != ST_RUN)) begin
          r_cnt <= '0;
          r_clk <= 1'b0;
          if (w_div_next != '0) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_adiv  <= w_div_next;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end else begin
          case (r_state)
            ST_RUN: begin
              if (w_base) begin
                if (w_wrap) begin
                  r_cnt  <= '0;
                  r_tick <= 1'b1;
                  r_clk  <= ~r_clk;
                  r_adiv <= w_div_next;
                  if (w_oneshot_next) begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                  end
                end else begin
                  r_cnt <= r_cnt + CW'(1);
                end
              end
            end
            ST_DONE: begin
              r_busy <= 1'b0;
            end
            default: begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
            end
          endcase
        end
      end
    end

    assign tick[i]    = r_tick;
    assign clk_out[i] = r_clk;
    assign busy[i]    = r_busy;
  end

endmodule
`default_nettype wire

// File: tb/tb_tick_sched_ctrl.sv
`default_nettype none
// Directed bench for tick_sched_ctrl with PRESCALE=4, NCH=4, CW=20.
module tb_tick_sched_ctrl;
  localparam int NCH      = 4;
  localparam int CW       = 20;
  localparam int PRESCALE = 4;
  localparam int AW       = 3;

  logic           clk_in  = 1'b0;
  logic           rst     = 1'b1;
  logic           wr_en   = 1'b0;
  logic [AW-1:0]  wr_addr = '0;
  logic [CW-1:0]  wr_data = '0;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  tick_sched_ctrl #(.NCH(NCH), .CW(CW), .PRESCALE(PRESCALE)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .tick   (tick),
    .clk_out(clk_out),
    .busy   (busy)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = addr[AW-1:0];
    wr_data = data[CW-1:0];
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input int maxc, output int at);
    bit found = 1'b0;
    at = -1;
    for (int i = 0; i < maxc && !found; i++) begin
      step();
      if (tick[ch]) begin
        found = 1'b1;
        at    = cyc;
      end
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL wait_tick_ch%0d: observed no tick, expected one within %0d cycles", ch, maxc);
    end
  endtask

  initial begin
    int       t1, t2, t3, w0, w1, w2, w3, w4, w5;
    int       hi, nt;
    logic     c1, c2;
    logic [2:0] acc2;
    logic [NCH-1:0] acc;

    // reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_tick", tick, 0);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // ch0 continuous, DIV=3 -> 12-cycle ticks, 24-cycle 50% clock
    wr(0, 3);
    wr(1, 1);
    chk("ch0_busy_after_enable", busy[0], 1);
    wait_tick(0, 16, t1);
    c1 = clk_out[0];
    chk("ch0_clk_first_wrap", c1, 1);
    step();
    chk("ch0_tick_one_cycle", tick[0], 0);
    wait_tick(0, 30, t2);
    c2 = clk_out[0];
    wait_tick(0, 30, t3);
    chk("ch0_period_a", t2 - t1, 12);
    chk("ch0_period_b", t3 - t2, 12);
    chk("ch0_clk_toggle", c2, !c1);
    hi = 0;
    for (int i = 0; i < 24; i++) begin
      if (clk_out[0]) hi++;
      if (i < 23) step();
    end
    chk("ch0_clk_duty", hi, 12);

    // ch1 one-shot DIV=2
    wr(2, 2);
    wr(3, 3);
    chk("ch1_busy_oneshot", busy[1], 1);
    wait_tick(1, 8, t1);
    chk("ch1_busy_falls_with_tick", busy[1], 0);
    nt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tick[1]) nt++;
    end
    chk("ch1_no_more_ticks", nt, 0);
    chk("ch1_done_clk_held", clk_out[1], 1);
    chk("ch1_done_busy", busy[1], 0);
    wr(3, 3);
    chk("ch1_rearm_busy", busy[1], 1);
    chk("ch1_rearm_clk_cleared", clk_out[1], 0);
    wait_tick(1, 8, t1);
    chk("ch1_rearm_busy_falls", busy[1], 0);

    // ch2 enable with DIV=0 is ignored
    wr(4, 0);
    wr(5, 1);
    acc2 = {busy[2], tick[2], clk_out[2]};
    for (int i = 0; i < 200; i++) begin
      step();
      acc2 = acc2 | {busy[2], tick[2], clk_out[2]};
    end
    chk("ch2_div0_quiet", acc2, 0);

    // ch0 DIV change mid-period, then back, then coincident with wrap
    wait_tick(0, 30, w0);
    wr(0, 5);
    wait_tick(0, 30, w1);
    wait_tick(0, 40, w2);
    chk("ch0_old_period_completes", w1 - w0, 12);
    chk("ch0_new_period_20", w2 - w1, 20);
    wr(0, 3);
    wait_tick(0, 40, w3);
    wait_tick(0, 30, w4);
    chk("ch0_period_20_completes", w3 - w2, 20);
    chk("ch0_back_to_12", w4 - w3, 12);
    repeat (11) step();
    wr(0, 5);
    w5 = cyc;
    chk("ch0_wrap_at_coincident_write", tick[0], 1);
    wait_tick(0, 40, w1);
    chk("ch0_coincident_period_20", w1 - w5, 20);

    // ch3 DIV=1, disable exactly on a wrap edge
    wr(6, 1);
    wr(7, 1);
    wait_tick(3, 8, t1);
    chk("ch3_clk_high", clk_out[3], 1);
    repeat (3) step();
    wr(7, 0);
    chk("ch3_tick_suppressed", tick[3], 0);
    chk("ch3_clk_forced_low", clk_out[3], 0);
    chk("ch3_busy_low", busy[3], 0);
    step();
    chk("ch3_stays_quiet", {busy[3], tick[3]}, 0);

    // all channels running, then reset (with a write that must be discarded)
    wr(3, 1);
    wr(4, 2);
    wr(5, 1);
    wr(7, 1);
    step();
    chk("all_busy", busy, 4'hF);
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 3'd2;
    wr_data = 20'd7;
    step();
    wr_en   = 1'b0;
    chk("midrst_tick", tick, 0);
    chk("midrst_clk_out", clk_out, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    wr(3, 1);
    chk("ch1_write_during_rst_discarded", busy[1], 0);
    wr(1, 1);
    chk("ch0_div_cleared_by_rst", busy[0], 0);
    acc = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      acc = acc | tick | busy | clk_out;
    end
    chk("post_rst_idle", acc, 0);
    wr(0, 3);
    wr(1, 1);
    chk("ch0_reenable_busy", busy[0], 1);
    wait_tick(0, 16, t1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/tick_sched_ctrl.md
Name: tick_sched_ctrl

Overview:
- Multi-channel timebase controller. One shared free-running prescaler generates a base tick; NCH independent channels divide that base tick by a register-programmed divisor.
- Each channel produces a one-cycle clock-enable pulse (tick) and a 50% square wave (clk_out).
- Supports continuous and one-shot modes. Configured through a simple write port by the control logic in the same clk_in domain.

Parameters:
- NCH, 4: number of channels (power of two, 2..8).
- CW, 20: channel divisor/counter width.
- PRESCALE, 50: clk_in cycles per base tick (≥2).

Ports:
- clk_in  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  register write strobe, one cycle per write.
- wr_addr  in  log2(NCH)+1  {channel index, sel}; sel=0 selects DIV, sel=1 selects CTRL.
- wr_data  in  CW  write data. For CTRL: bit0=enable, bit1=oneshot; other bits ignored.
- tick  out  NCH  per-channel one-cycle pulse at each divisor wrap.
- clk_out  out  NCH  per-channel square wave; toggles on each wrap.
- busy  out  NCH  high while the channel is in RUN.

Behaviour:
- Reset (rst=1 at an edge):
  - prescaler count, all channel counters, shadow DIV, active DIV and CTRL cleared.
  - all channels to IDLE; tick=0, clk_out=0, busy=0 from the next cycle.
  - Applies mid-operation with no exceptions.
- Prescaler:
  - counts 0..PRESCALE-1 and wraps.
  - internal base_tick is high in the cycle the count equals PRESCALE-1.
  - free-running; never restarted by channel writes. First channel period may therefore be short by up to PRESCALE-1 cycles.
- DIV write: loads the channel's shadow DIV only.
  - Active DIV loads from shadow on entry to RUN and at every wrap.
  - If a DIV write coincides with a wrap, active DIV loads wr_data.
  - The period in progress always completes with the old active DIV.
- CTRL write: stores the oneshot bit, then:
  - enable=1 from IDLE or DONE, with shadow DIV≠0 (or coincident DIV write≠0): next state RUN, counter=0, clk_out=0, active DIV loaded.
  - enable=1 while RUN: mode bit updated only; counting continues uninterrupted.
  - enable=1 with DIV=0: ignored; channel stays or returns to IDLE; busy=0.
  - enable=0: next state IDLE, counter cleared, clk_out forced 0, any pending tick suppressed.
- Channel FSM:
  - IDLE: counter held at 0.
  - RUN: on each base_tick, if counter==active DIV-1 it is a wrap; otherwise counter+1.
  - At a wrap: counter=0, tick pulses high for exactly one cycle (registered, in the cycle after the wrapping base_tick), clk_out toggles in that same cycle.
    - continuous mode: stays RUN.
    - oneshot mode: goes to DONE; busy falls in the same cycle tick rises.
  - DONE: outputs held (clk_out keeps its last value, tick=0). Leaves only on a CTRL write.
- Timing: continuous tick period = DIV×PRESCALE clk_in cycles; clk_out period = 2×DIV×PRESCALE.
- Counter compare is CW bits unsigned, so DIV=2^CW-1 is the maximum period; no overflow path.
- Channels are fully independent. Simultaneous wraps on multiple channels all pulse tick in the same cycle.
- Writes take effect at the edge where wr_en is sampled; state visible next cycle. Write to an address while rst=1 is discarded.

Test Plan (PRESCALE=4, NCH=4, CW=20):
- Reset, ch0 DIV=3, CTRL=01 → busy[0]=1 next cycle; tick[0] every 12 clk_in cycles exactly from the 2nd pulse on; clk_out[0] period 24; 50% duty.
- ch1 DIV=2, CTRL=11 (oneshot) → exactly one tick[1] pulse within 8 cycles after entry; busy[1] falls with tick; no further ticks over 100 cycles. Rewrite CTRL=11 → one more pulse.
- ch2 DIV=0, CTRL=01 → busy[2]=0, tick[2]=0, clk_out[2]=0 for 200 cycles.
- ch0 running DIV=3; write DIV=5 mid-period → current period 12 cycles; subsequent periods 20 cycles. DIV write in the exact wrap cycle → next period 20 cycles immediately.
- ch3 running DIV=1 (tick every 4 cycles); CTRL=00 in a base_tick wrap cycle → no tick[3] next cycle, clk_out[3]=0, busy[3]=0.
- All four channels running; assert rst for one cycle → all tick, clk_out, busy 0 next cycle. After release, channels stay IDLE until re-enabled and DIV reads as cleared (enable without a DIV write is ignored).
